tile_map_renderer: RTL and testbench
====================================

// Module: tile_map_renderer
// PURPOSE
//  Parametrised tile-map rasteriser. Walks a MAP_W x MAP_H tile map and fetches each tile type from the map RAM.
//  Expands each tile into TILE x TILE pixels through a sprite bitmap lookup, then streams plot requests to the VGA adapter.
//  Improvements: start/busy/done handshake, one-shot or continuous frames, 1-cycle registered map RAM,
//  VGA back-pressure (vga_ready), optional skip of blank pixels. Sits between MapController and the VGA adapter.
// PARAMETERS
//  MAP_W    21  tiles per map row
//  MAP_H    21  tile rows per map
//  TILE      5  tile edge in pixels (2..8)
//  X_ORG    26  screen x of tile (0,0) pixel (0,0)
//  Y_ORG     1  screen y of tile (0,0) pixel (0,0)
//  MAP_AW    5  width of map_x/map_y; 2**MAP_AW >= max(MAP_W,MAP_H)
//  COORD_W   8  width of vga_x/vga_y; X_ORG+MAP_W*TILE and Y_ORG+MAP_H*TILE <= 2**COORD_W
//  COLOR_W   3  colour width
// PORTS
//  clock_50     in   1        system clock, all logic on posedge
//  reset        in   1        asynchronous, active-low reset
//  start        in   1        begin a frame; sampled only in IDLE
//  continuous   in   1        sampled with start: 1 = restart after each frame until cleared
//  skip_blank   in   1        1 = do not plot pixels whose bitmap bit is 0
//  map_x        out  MAP_AW   tile column address to MapController
//  map_y        out  MAP_AW   tile row address to MapController
//  sprite_type  in   3        tile type; valid 1 cycle after map_x/map_y
//  vga_ready    in   1        adapter accepts a plot this cycle
//  vga_plot     out  1        plot request (registered)
//  vga_x        out  COORD_W  pixel x (registered)
//  vga_y        out  COORD_W  pixel y (registered)
//  vga_color    out  COLOR_W  pixel colour (registered)
//  busy         out  1        high from FETCH of first tile until DONE
//  done         out  1        1-cycle pulse at end of every frame
// BEHAVIOUR
//  Reset (reset=0, async): state IDLE; map_x=map_y=0; px=py=0; vga_plot=0; vga_x=vga_y=0; vga_color=0;
//   busy=0; done=0; cont_q=0. Reset mid-frame abandons the frame and issues no done.
//  FSM: IDLE -> FETCH on start=1 (cont_q<=continuous).
//   FETCH: 1 cycle, map_x/map_y stable; sprite_type latched into type_q at the end of the cycle.
//   DRAW:  emits TILE*TILE pixels, px fastest then py; one pixel per cycle when vga_ready=1.
//   After the last pixel of the tile -> FETCH of next tile (map_x++, on MAP_W-1 wrap to 0 and map_y++).
//   After the last pixel of tile (MAP_W-1,MAP_H-1) -> DONE.
//   DONE: 1 cycle, done=1, map_x=map_y=0. Next state FETCH if cont_q && continuous, else IDLE.
//  start while busy: ignored. Clearing continuous mid-frame finishes the current frame, then goes IDLE.
//  Pixel output (registered, 1-cycle latency from counter):
//   vga_x = X_ORG + map_x*TILE + px; vga_y = Y_ORG + map_y*TILE + py, computed at COORD_W, mod 2**COORD_W.
//   bit = bitmap(type_q, py, px); vga_color = bit ? colour(type_q) : 0.
//   vga_plot = 1 in DRAW unless (skip_blank && !bit); vga_plot = 0 in IDLE/FETCH/DONE.
//  Back-pressure: in DRAW with vga_ready=0, the counters and all vga_* outputs hold. A pending plot is held until accepted.
//   vga_ready is ignored when vga_plot=0.
//  Frame time with vga_ready=1: MAP_W*MAP_H*(1+TILE*TILE)+1 cycles (defaults: 11467).
//  Sprite set at TILE=5 (row bit0 = leftmost pixel):
//   0 black all-0/000; 1 big orb 00000,00100,01110,00100,00000/111; 2 small orb centre bit/111;
//   3 wall solid/001; 4 and 5-7 solid/010.
//   For other TILE values orbs are centred, with the big orb radius TILE/4.
// STRUCTURE
//  Shared package pacman_pkg: sprite type codes (SPR_BLACK..SPR_GREY), colour constants, TILE_DEFAULT.
//  Sub-module tile_sprite_rom (combinational): in type, row, col; out bit, colour. Parametrised by TILE and COLOR_W.
//  The top holds the FSM, tile/pixel counters, the type_q latch and the output registers.
// TESTING
//  Reset then start=1, continuous=0, vga_ready=1, all tiles type 3 ->
//   first plot (26,1) colour 001; last (130,105); done once at cycle 11467; busy then 0; 441*25 plots.
//  Tile (0,0) type 1, skip_blank=1 ->
//   exactly 5 plots at (28,2),(27,3),(28,3),(29,3),(28,4), all colour 111.
//  vga_ready toggled 0/1 every cycle during DRAW -> identical plot sequence to the previous test, no pixel lost or duplicated.
//  continuous=1 for 2 frames then cleared -> done pulses at the end of each frame;
//   third frame completes then IDLE; busy never drops between frames.
//  Assert reset=0 mid-tile (map 7,3 px 2) -> all outputs 0 immediately; no done.
//   After start, the first fetch is (0,0).
//  Pulse start while busy=1 -> ignored; frame length and plot count unchanged.

Source files
------------

// File: rtl/pacman_pkg.sv
// Shared definitions for the Pac-Man tile renderer: sprite codes, palette and FSM states.
package pacman_pkg;

   localparam int TILE_DEFAULT = 5;

   typedef enum logic [2:0] {
      SPR_BLACK     = 3'd0,
      SPR_BIG_ORB   = 3'd1,
      SPR_SMALL_ORB = 3'd2,
      SPR_WALL      = 3'd3,
      SPR_GREY      = 3'd4
   } sprite_e;

   localparam logic [2:0] COL_BLACK = 3'b000;
   localparam logic [2:0] COL_WHITE = 3'b111;
   localparam logic [2:0] COL_BLUE  = 3'b001;
   localparam logic [2:0] COL_GREY  = 3'b010;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DRAW,
      ST_DONE
   } state_e;

endpackage

// File: rtl/tile_sprite_rom.sv
// Combinational sprite bitmap: pixel bit and colour for a tile type at (row, col).
module tile_sprite_rom
   import pacman_pkg::*;
#(
   parameter int TILE    = TILE_DEFAULT,
   parameter int COLOR_W = 3
) (
   input  logic [2:0]         spr_type_i,
   input  logic [2:0]         row_i,
   input  logic [2:0]         col_i,
   output logic               bit_o,
   output logic [COLOR_W-1:0] color_o
);

   localparam logic [2:0] CTR = 3'(TILE / 2);
   localparam logic [3:0] RAD = 4'(TILE / 4);

   logic [2:0] dr;
   logic [2:0] dc;
   logic       on_big;
   logic       on_small;

   // Orbs are diamonds around the tile centre: Manhattan distance <= radius.
   always_comb begin
      dr       = (row_i >= CTR) ? row_i - CTR : CTR - row_i;
      dc       = (col_i >= CTR) ? col_i - CTR : CTR - col_i;
      on_big   = ({1'b0, dr} + {1'b0, dc}) <= RAD;
      on_small = (dr == 3'd0) && (dc == 3'd0);
      case (spr_type_i)
         SPR_BLACK: begin
            bit_o   = 1'b0;
            color_o = COLOR_W'(COL_BLACK);
         end
         SPR_BIG_ORB: begin
            bit_o   = on_big;
            color_o = COLOR_W'(COL_WHITE);
         end
         SPR_SMALL_ORB: begin
            bit_o   = on_small;
            color_o = COLOR_W'(COL_WHITE);
         end
         SPR_WALL: begin
            bit_o   = 1'b1;
            color_o = COLOR_W'(COL_BLUE);
         end
         SPR_GREY: begin
            bit_o   = 1'b1;
            color_o = COLOR_W'(COL_GREY);
         end
         default: begin
            bit_o   = 1'b1;
            color_o = COLOR_W'(COL_GREY);
         end
      endcase
   end

endmodule

// File: rtl/tile_map_renderer.sv
// Tile-map rasteriser: walks the map, fetches tile types and streams sprite pixels to the VGA adapter.
module tile_map_renderer
   import pacman_pkg::*;
#(
   parameter int MAP_W   = 21,
   parameter int MAP_H   = 21,
   parameter int TILE    = 5,
   parameter int X_ORG   = 26,
   parameter int Y_ORG   = 1,
   parameter int MAP_AW  = 5,
   parameter int COORD_W = 8,
   parameter int COLOR_W = 3
) (
   input  logic               clock_50,
   input  logic               reset,
   input  logic               start,
   input  logic               continuous,
   input  logic               skip_blank,
   output logic [MAP_AW-1:0]  map_x,
   output logic [MAP_AW-1:0]  map_y,
   input  logic [2:0]         sprite_type,
   input  logic               vga_ready,
   output logic               vga_plot,
   output logic [COORD_W-1:0] vga_x,
   output logic [COORD_W-1:0] vga_y,
   output logic [COLOR_W-1:0] vga_color,
   output logic               busy,
   output logic               done
);

   localparam logic [2:0]        PX_LAST = 3'(TILE - 1);
   localparam logic [MAP_AW-1:0] MX_LAST = MAP_AW'(MAP_W - 1);
   localparam logic [MAP_AW-1:0] MY_LAST = MAP_AW'(MAP_H - 1);

   state_e             state_q;
   logic [MAP_AW-1:0]  map_x_q, map_y_q, tx_q, ty_q;
   logic [MAP_AW-1:0]  map_x_d, map_y_d;
   logic [2:0]         px_q, py_q, type_q;
   logic               cont_q, busy_q, done_q, plot_q;
   logic [COORD_W-1:0] vx_q, vy_q, vx_d, vy_d;
   logic [COLOR_W-1:0] col_q;

   logic               pix_bit;
   logic [COLOR_W-1:0] pix_col;
   logic               stall, px_wrap, tile_last, pre_last, frame_last;

   tile_sprite_rom #(
      .TILE    (TILE),
      .COLOR_W (COLOR_W)
   ) u_rom (
      .spr_type_i (type_q),
      .row_i      (py_q),
      .col_i      (px_q),
      .bit_o      (pix_bit),
      .color_o    (pix_col)
   );

   assign stall      = plot_q && !vga_ready;
   assign px_wrap    = (px_q == PX_LAST);
   assign tile_last  = px_wrap && (py_q == PX_LAST);
   assign pre_last   = (px_q == PX_LAST - 3'd1) && (py_q == PX_LAST);
   assign frame_last = tile_last && (tx_q == MX_LAST) && (ty_q == MY_LAST);

   assign vx_d = COORD_W'(X_ORG) + COORD_W'(tx_q) * COORD_W'(TILE) + COORD_W'(px_q);
   assign vy_d = COORD_W'(Y_ORG) + COORD_W'(ty_q) * COORD_W'(TILE) + COORD_W'(py_q);

   always_comb begin
      map_x_d = map_x_q + 1'b1;
      map_y_d = map_y_q;
      if (map_x_q == MX_LAST) begin
         map_x_d = '0;
         map_y_d = (map_y_q == MY_LAST) ? '0 : map_y_q + 1'b1;
      end
   end

   // The map address moves to the next tile while the last pixel of the current
   // tile is drawn, so the registered map RAM has data ready during FETCH; the
   // drawn tile's position lives in tx_q/ty_q. Back-pressure only freezes DRAW;
   // a pending plot survives FETCH/DONE/IDLE because the output stage holds too.
   always_ff @(posedge clock_50 or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         map_x_q <= '0;
         map_y_q <= '0;
         tx_q    <= '0;
         ty_q    <= '0;
         px_q    <= '0;
         py_q    <= '0;
         type_q  <= '0;
         cont_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         plot_q  <= 1'b0;
         vx_q    <= '0;
         vy_q    <= '0;
         col_q   <= '0;
      end else begin
         done_q <= 1'b0;
         if (!stall) begin
            if (state_q == ST_DRAW) begin
               plot_q <= pix_bit || !skip_blank;
               vx_q   <= vx_d;
               vy_q   <= vy_d;
               col_q  <= pix_bit ? pix_col : '0;
            end else begin
               plot_q <= 1'b0;
            end
         end
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_q <= ST_FETCH;
                  cont_q  <= continuous;
                  busy_q  <= 1'b1;
               end
            end
            ST_FETCH: begin
               type_q  <= sprite_type;
               tx_q    <= map_x_q;
               ty_q    <= map_y_q;
               px_q    <= '0;
               py_q    <= '0;
               state_q <= ST_DRAW;
            end
            ST_DRAW: begin
               if (!stall) begin
                  if (pre_last) begin
                     map_x_q <= map_x_d;
                     map_y_q <= map_y_d;
                  end
                  if (tile_last) begin
                     state_q <= frame_last ? ST_DONE : ST_FETCH;
                     done_q  <= frame_last;
                  end else if (px_wrap) begin
                     px_q <= '0;
                     py_q <= py_q + 3'd1;
                  end else begin
                     px_q <= px_q + 3'd1;
                  end
               end
            end
            ST_DONE: begin
               if (cont_q && continuous) begin
                  state_q <= ST_FETCH;
               end else begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            end
         endcase
      end
   end

   assign map_x     = map_x_q;
   assign map_y     = map_y_q;
   assign vga_plot  = plot_q;
   assign vga_x     = vx_q;
   assign vga_y     = vy_q;
   assign vga_color = col_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_tile_map_renderer.sv
// Directed and randomized frames checked against a pixel-list model of the tile map.
module tb_tile_map_renderer;

   localparam int MAP_W = 21;
   localparam int MAP_H = 21;
   localparam int TILE  = 5;
   localparam int X_ORG = 26;
   localparam int Y_ORG = 1;
   localparam int NT    = MAP_W * MAP_H;
   localparam int FRAME_CYC = NT * (1 + TILE * TILE) + 1;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       start = 1'b0, continuous = 1'b0, skip_blank = 1'b0, vga_ready = 1'b1;
   logic [4:0] map_x, map_y;
   logic [2:0] sprite_type;
   logic       vga_plot, busy, done;
   logic [7:0] vga_x, vga_y;
   logic [2:0] vga_color;

   int n_cmp = 0;
   int n_fail = 0;

   logic [2:0]  map_mem [NT];
   logic [18:0] got_q[$];
   logic [18:0] exp_q[$];
   logic [18:0] five [5];
   int done_cnt, done_cyc, cyc, gap, lim;

   tile_map_renderer #(
      .MAP_W(21), .MAP_H(21), .TILE(5), .X_ORG(26), .Y_ORG(1),
      .MAP_AW(5), .COORD_W(8), .COLOR_W(3)
   ) dut (
      .clock_50(clk), .reset(rst_n), .start(start), .continuous(continuous),
      .skip_blank(skip_blank), .map_x(map_x), .map_y(map_y), .sprite_type(sprite_type),
      .vga_ready(vga_ready), .vga_plot(vga_plot), .vga_x(vga_x), .vga_y(vga_y),
      .vga_color(vga_color), .busy(busy), .done(done)
   );

   always #10 clk = ~clk;

   // Registered map RAM: data appears one cycle after the address.
   always @(posedge clk) sprite_type <= map_mem[int'(map_y) * MAP_W + int'(map_x)];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic pix_on(input logic [2:0] t, input int r, input int c);
      logic [4:0] big [5];
      big[0] = 5'b00000; big[1] = 5'b00100; big[2] = 5'b01110;
      big[3] = 5'b00100; big[4] = 5'b00000;
      case (t)
         3'd0:    return 1'b0;
         3'd1:    return big[r][c];
         3'd2:    return (r == 2) && (c == 2);
         default: return 1'b1;
      endcase
   endfunction

   function automatic logic [2:0] col_of(input logic [2:0] t);
      case (t)
         3'd0:        return 3'b000;
         3'd1, 3'd2:  return 3'b111;
         3'd3:        return 3'b001;
         default:     return 3'b010;
      endcase
   endfunction

   task automatic build_exp(input bit skip, input int reps);
      logic [2:0] t;
      logic       on;
      exp_q.delete();
      for (int f = 0; f < reps; f++)
         for (int ty = 0; ty < MAP_H; ty++)
            for (int tx = 0; tx < MAP_W; tx++)
               for (int py = 0; py < TILE; py++)
                  for (int px = 0; px < TILE; px++) begin
                     t  = map_mem[ty * MAP_W + tx];
                     on = pix_on(t, py, px);
                     if (on || !skip)
                        exp_q.push_back({8'(X_ORG + tx * TILE + px), 8'(Y_ORG + ty * TILE + py),
                                         on ? col_of(t) : 3'b000});
                  end
   endtask

   // rdy_mode: 0 always ready, 1 toggle each cycle, 2 random ~85% ready
   task automatic run_frames(input int rdy_mode, input bit cont, input bit poke_start);
      bit started = 1'b0;
      got_q.delete();
      done_cnt = 0; done_cyc = -1; cyc = 0; gap = 0; lim = 0;
      continuous = cont;
      start = 1'b1;
      forever begin
         @(posedge clk); #1;
         start = 1'b0;
         if (poke_start && cyc == 5000) start = 1'b1;
         if (cont && done_cnt == 2 && !done) continuous = 1'b0;
         case (rdy_mode)
            0:       vga_ready = 1'b1;
            1:       vga_ready = ~vga_ready;
            default: vga_ready = ($urandom_range(99) < 85);
         endcase
         if (busy) begin
            started = 1'b1;
            cyc++;
         end else if (started && done_cnt < (cont ? 3 : 1)) begin
            gap++;
         end
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
         end
         if (vga_plot && vga_ready) got_q.push_back({vga_x, vga_y, vga_color});
         lim++;
         if ((started && !busy && !vga_plot) || lim > 60000) break;
      end
      check("frame_terminates", lim <= 60000, 1);
      vga_ready  = 1'b1;
      continuous = 1'b0;
   endtask

   task automatic cmp_seq(input string tag);
      int bad = 0;
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         if (got_q[i] !== exp_q[i]) bad++;
      check({tag, "_count"}, got_q.size(), exp_q.size());
      check({tag, "_pixels_wrong"}, bad, 0);
   endtask

   initial begin
      bit hit, seen;
      for (int i = 0; i < NT; i++) map_mem[i] = 3'd3;
      five[0] = {8'd28, 8'd2, 3'd7}; five[1] = {8'd27, 8'd3, 3'd7};
      five[2] = {8'd28, 8'd3, 3'd7}; five[3] = {8'd29, 8'd3, 3'd7};
      five[4] = {8'd28, 8'd4, 3'd7};

      #2 rst_n = 1'b0;
      #5;
      check("reset_outputs", {map_x, map_y, vga_plot, vga_x, vga_y, vga_color, busy, done}, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // All walls, always ready, start pulsed mid-frame
      skip_blank = 1'b0;
      build_exp(1'b0, 1);
      run_frames(0, 1'b0, 1'b1);
      check("A_done_count", done_cnt, 1);
      check("A_done_cycle", done_cyc, FRAME_CYC);
      check("A_busy_gap", gap, 0);
      check("A_busy_after", busy, 0);
      check("A_plot_count", got_q.size(), 441 * 25);
      check("A_first_plot", got_q[0], {8'd26, 8'd1, 3'd1});
      check("A_last_plot", got_q[$], {8'd130, 8'd105, 3'd1});
      cmp_seq("A_seq");

      // Big orb at (0,0), everything else black, blanks skipped
      for (int i = 0; i < NT; i++) map_mem[i] = 3'd0;
      map_mem[0] = 3'd1;
      skip_blank = 1'b1;
      build_exp(1'b1, 1);
      run_frames(0, 1'b0, 1'b0);
      check("B_plot_count", got_q.size(), 5);
      for (int i = 0; i < 5; i++) check($sformatf("B_plot%0d", i), got_q[i], five[i]);
      check("B_done_cycle", done_cyc, FRAME_CYC);
      cmp_seq("B_seq");

      // Same map with ready toggling every cycle
      run_frames(1, 1'b0, 1'b0);
      check("C_done_count", done_cnt, 1);
      for (int i = 0; i < 5; i++) check($sformatf("C_plot%0d", i), got_q[i], five[i]);
      cmp_seq("C_seq");

      // Reset mid-tile at map (7,3)
      for (int i = 0; i < NT; i++) map_mem[i] = 3'd3;
      skip_blank = 1'b0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      hit = 1'b0;
      for (int k = 0; k < 5000 && !hit; k++) begin
         @(posedge clk); #1;
         if (vga_plot && vga_x == 8'd63 && vga_y == 8'd16) hit = 1'b1;
      end
      check("R_reached_tile_7_3", hit, 1);
      rst_n = 1'b0;
      #1;
      check("R_outputs_cleared", {map_x, map_y, vga_plot, vga_x, vga_y, vga_color, busy, done}, 0);
      seen = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         if (done) seen = 1'b1;
      end
      check("R_no_done", seen, 0);
      rst_n = 1'b1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("R_restart_busy", busy, 1);
      check("R_first_fetch_addr", {map_x, map_y}, 0);
      hit = 1'b0;
      for (int k = 0; k < 40 && !hit; k++) begin
         @(posedge clk); #1;
         if (vga_plot) hit = 1'b1;
      end
      check("R_first_plot", {vga_x, vga_y, vga_color}, {8'd26, 8'd1, 3'd1});
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Continuous: random map, random back-pressure, cleared after two frames
      for (int i = 0; i < NT; i++) map_mem[i] = 3'($urandom_range(7));
      skip_blank = 1'($urandom_range(1));
      build_exp(skip_blank, 3);
      run_frames(2, 1'b1, 1'b0);
      check("D_done_count", done_cnt, 3);
      check("D_busy_gap", gap, 0);
      cmp_seq("D_seq");
      seen = 1'b0;
      repeat (20) begin
         @(posedge clk); #1;
         if (busy || done) seen = 1'b1;
      end
      check("D_stays_idle", seen, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
